// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
// Module : npc_pkg
// Brief  : Shared NPC core types and constants (fetch state, reset PC, align).
// Rev    : 1.0
// ============================================================================
package npc_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam int          INSTR_ALIGN      = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DROP = 3'd3,
        ST_OUT  = 3'd4
    } fetch_state_e;

endpackage : npc_pkg
`default_nettype wire

// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
// Module : ifu_fetch_if
// Brief  : Instruction-memory, redirect and decode handshake bundle for fetch.
// Rev    : 1.0
// ============================================================================
interface ifu_fetch_if #(
    parameter int DW = 64,
    parameter int IW = 32
);
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [DW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;
    logic          id_valid;
    logic          id_ready;
    logic [IW-1:0] id_instr;
    logic [DW-1:0] id_pc;

    // master: the fetch stage; slave: memory, execute and decode around it
    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

endinterface : ifu_fetch_if
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module : ifu_fetch
// Brief  : Single-outstanding instruction fetch FSM with one-entry output buffer.
// Rev    : 1.0
// ============================================================================
module ifu_fetch
    import npc_pkg::*;
#(
    parameter int              DW       = 64,
    parameter int              IW       = 32,
    parameter logic [DW-1:0]   RESET_PC = DW'(RESET_PC_DEFAULT)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    ifu_fetch_if.master      bus
);

    localparam logic [DW-1:0] c_pc_step   = DW'(INSTR_ALIGN);
    localparam logic [DW-1:0] c_align_msk = ~DW'(INSTR_ALIGN - 1);

    fetch_state_e  state_q, state_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [IW-1:0] instr_buf_q, instr_buf_d;
    logic [DW-1:0] pc_buf_q, pc_buf_d;

    logic [DW-1:0] w_redir_pc;

    assign w_redir_pc = bus.redirect_pc & c_align_msk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            instr_buf_q <= '0;
            pc_buf_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_buf_q <= instr_buf_d;
            pc_buf_q    <= pc_buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_buf_d = instr_buf_q;
        pc_buf_d    = pc_buf_q;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;

            ST_REQ: begin
                if (bus.redirect_valid) begin
                    pc_d = w_redir_pc;
                    // An accepted request now targets a stale PC; its response must be eaten.
                    state_d = bus.imem_req_ready ? ST_DROP : ST_REQ;
                end else if (bus.imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d    = w_redir_pc;
                    state_d = bus.imem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (bus.imem_rsp_valid) begin
                    instr_buf_d = bus.imem_rsp_data;
                    pc_buf_d    = pc_q;
                    pc_d        = pc_q + c_pc_step;
                    state_d     = ST_OUT;
                end
            end

            ST_DROP: begin
                if (bus.redirect_valid) begin
                    pc_d = w_redir_pc;
                end
                if (bus.imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end

            ST_OUT: begin
                if (bus.redirect_valid) begin
                    pc_d    = w_redir_pc;
                    state_d = ST_REQ;
                end else if (bus.id_ready) begin
                    state_d = ST_REQ;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Redirect masks id_valid so a same-cycle id_ready never completes a flushed handshake.
    assign bus.imem_req_valid = (state_q == ST_REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.id_valid       = (state_q == ST_OUT) && !bus.redirect_valid;
    assign bus.id_instr       = instr_buf_q;
    assign bus.id_pc          = pc_buf_q;

endmodule : ifu_fetch
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_ifu_fetch
// Brief  : Directed self-checking bench for ifu_fetch (main and wrap-around PC).
// Rev    : 1.0
// ============================================================================
module tb_ifu_fetch;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    ifu_fetch_if #(.DW(64), .IW(32)) ifa ();
    ifu_fetch_if #(.DW(64), .IW(32)) ifb ();

    ifu_fetch #(.DW(64), .IW(32)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    ifu_fetch #(.DW(64), .IW(32), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        ifa.imem_rsp_valid = 1'b0;
        ifa.imem_rsp_data  = '0;
        ifa.redirect_valid = 1'b0;
        ifa.redirect_pc    = '0;
        ifa.id_ready       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        clear_a();
        ifa.imem_req_ready = 1'b0;
        ifb.imem_req_ready = 1'b0;
        ifb.imem_rsp_valid = 1'b0;
        ifb.imem_rsp_data  = '0;
        ifb.redirect_valid = 1'b0;
        ifb.redirect_pc    = '0;
        ifb.id_ready       = 1'b0;

        // reset values
        repeat (3) tick();
        check_val("rst_req_valid", 64'(ifa.imem_req_valid), 64'd0);
        check_val("rst_id_valid",  64'(ifa.id_valid),       64'd0);
        check_val("rst_id_instr",  64'(ifa.id_instr),       64'd0);
        check_val("rst_id_pc",     ifa.id_pc,               64'd0);
        check_val("rst_req_addr",  ifa.imem_req_addr,       64'h8000_0000);

        // reset and fetch
        rst_n = 1'b1;
        ifa.imem_req_ready = 1'b1;
        tick();                                   // IDLE -> REQ
        check_val("f1_req_valid", 64'(ifa.imem_req_valid), 64'd1);
        check_val("f1_req_addr",  ifa.imem_req_addr,       64'h8000_0000);
        tick();                                   // accepted -> WAIT
        check_val("f1_wait_req_valid", 64'(ifa.imem_req_valid), 64'd0);
        ifa.imem_rsp_valid = 1'b1;
        ifa.imem_rsp_data  = 32'h0000_0013;
        tick();                                   // WAIT -> OUT
        clear_a();
        check_val("f1_id_valid", 64'(ifa.id_valid), 64'd1);
        check_val("f1_id_instr", 64'(ifa.id_instr), 64'h13);
        check_val("f1_id_pc",    ifa.id_pc,         64'h8000_0000);

        // decode backpressure: 5 stalled cycles, handshake on the 6th
        for (int i = 0; i < 5; i++) begin
            check_val("bp_id_valid",  64'(ifa.id_valid),       64'd1);
            check_val("bp_id_instr",  64'(ifa.id_instr),       64'h13);
            check_val("bp_id_pc",     ifa.id_pc,               64'h8000_0000);
            check_val("bp_req_valid", 64'(ifa.imem_req_valid), 64'd0);
            tick();
        end
        ifa.id_ready = 1'b1;
        #1;
        check_val("bp_hs_id_valid", 64'(ifa.id_valid), 64'd1);
        tick();                                   // OUT -> REQ
        ifa.id_ready = 1'b0;
        check_val("f2_req_valid", 64'(ifa.imem_req_valid), 64'd1);
        check_val("f2_req_addr",  ifa.imem_req_addr,       64'h8000_0004);
        check_val("f2_id_valid",  64'(ifa.id_valid),       64'd0);

        // redirect in WAIT, stale response two cycles later
        tick();                                   // REQ -> WAIT
        ifa.redirect_valid = 1'b1;
        ifa.redirect_pc    = 64'h8000_1000;
        tick();                                   // WAIT -> DROP
        clear_a();
        check_val("rw_drop_req_valid", 64'(ifa.imem_req_valid), 64'd0);
        tick();
        ifa.imem_rsp_valid = 1'b1;
        ifa.imem_rsp_data  = 32'hdead_beef;
        #1;
        check_val("rw_drop_id_valid", 64'(ifa.id_valid), 64'd0);
        tick();                                   // DROP -> REQ
        clear_a();
        check_val("rw_id_valid",  64'(ifa.id_valid),       64'd0);
        check_val("rw_req_valid", 64'(ifa.imem_req_valid), 64'd1);
        check_val("rw_req_addr",  ifa.imem_req_addr,       64'h8000_1000);

        // redirect with rsp_valid in the same WAIT cycle
        tick();                                   // REQ -> WAIT
        ifa.redirect_valid = 1'b1;
        ifa.redirect_pc    = 64'h8000_2000;
        ifa.imem_rsp_valid = 1'b1;
        ifa.imem_rsp_data  = 32'hdead_beef;
        tick();                                   // WAIT -> REQ
        clear_a();
        check_val("rr_id_valid",  64'(ifa.id_valid),       64'd0);
        check_val("rr_req_valid", 64'(ifa.imem_req_valid), 64'd1);
        check_val("rr_req_addr",  ifa.imem_req_addr,       64'h8000_2000);

        // normal fetch at the redirected PC
        tick();                                   // REQ -> WAIT
        ifa.imem_rsp_valid = 1'b1;
        ifa.imem_rsp_data  = 32'h0010_0093;
        tick();                                   // WAIT -> OUT
        clear_a();
        check_val("f3_id_valid", 64'(ifa.id_valid), 64'd1);
        check_val("f3_id_instr", 64'(ifa.id_instr), 64'h0010_0093);
        check_val("f3_id_pc",    ifa.id_pc,         64'h8000_2000);

        // redirect with id_ready in the same OUT cycle, unaligned target
        ifa.id_ready       = 1'b1;
        ifa.redirect_valid = 1'b1;
        ifa.redirect_pc    = 64'h8000_1003;
        #1;
        check_val("ro_id_valid_masked", 64'(ifa.id_valid), 64'd0);
        tick();                                   // OUT -> REQ
        clear_a();
        check_val("ro_req_valid", 64'(ifa.imem_req_valid), 64'd1);
        check_val("ro_req_addr",  ifa.imem_req_addr,       64'h8000_1000);

        // redirect in REQ while memory stalls: address follows redirect
        ifa.imem_req_ready = 1'b0;
        ifa.redirect_valid = 1'b1;
        ifa.redirect_pc    = 64'h8000_3000;
        tick();
        clear_a();
        check_val("rq_req_valid", 64'(ifa.imem_req_valid), 64'd1);
        check_val("rq_req_addr",  ifa.imem_req_addr,       64'h8000_3000);

        // redirect in REQ on accept -> DROP; later redirect in DROP wins
        ifa.imem_req_ready = 1'b1;
        ifa.redirect_valid = 1'b1;
        ifa.redirect_pc    = 64'h8000_4000;
        tick();                                   // REQ -> DROP
        clear_a();
        check_val("rd_req_valid", 64'(ifa.imem_req_valid), 64'd0);
        ifa.redirect_valid = 1'b1;
        ifa.redirect_pc    = 64'h8000_5000;
        tick();                                   // stays DROP
        clear_a();
        check_val("rd_drop_req_valid", 64'(ifa.imem_req_valid), 64'd0);
        ifa.imem_rsp_valid = 1'b1;
        ifa.imem_rsp_data  = 32'hdead_beef;
        tick();                                   // DROP -> REQ
        clear_a();
        check_val("rd_id_valid",  64'(ifa.id_valid),       64'd0);
        check_val("rd_req_valid2", 64'(ifa.imem_req_valid), 64'd1);
        check_val("rd_req_addr",  ifa.imem_req_addr,       64'h8000_5000);

        // asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mr_req_valid", 64'(ifa.imem_req_valid), 64'd0);
        check_val("mr_req_addr",  ifa.imem_req_addr,       64'h8000_0000);
        check_val("mr_id_pc",     ifa.id_pc,               64'd0);
        check_val("mr_id_instr",  64'(ifa.id_instr),       64'd0);
        tick();
        rst_n = 1'b1;

        // wrap-around on second instance
        tick();                                   // IDLE -> REQ
        check_val("wr_req_valid", 64'(ifb.imem_req_valid), 64'd1);
        check_val("wr_req_addr",  ifb.imem_req_addr,       64'hFFFF_FFFF_FFFF_FFFC);
        ifb.imem_req_ready = 1'b1;
        tick();                                   // REQ -> WAIT
        ifb.imem_rsp_valid = 1'b1;
        ifb.imem_rsp_data  = 32'h0000_0013;
        tick();                                   // WAIT -> OUT
        ifb.imem_rsp_valid = 1'b0;
        check_val("wr_id_valid", 64'(ifb.id_valid), 64'd1);
        check_val("wr_id_pc",    ifb.id_pc,         64'hFFFF_FFFF_FFFF_FFFC);
        ifb.id_ready = 1'b1;
        tick();                                   // OUT -> REQ
        ifb.id_ready = 1'b0;
        check_val("wr_next_valid", 64'(ifb.imem_req_valid), 64'd1);
        check_val("wr_next_addr",  ifb.imem_req_addr,       64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_ifu_fetch
`default_nettype wire
